// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   state_e           sequencer states
//   REG_ZERO          hardwired-zero register number (never a real dependency)
//   DRAIN_CYCLES_DFLT default bubble cycles after a halt leaves ID (EXE+MEM+WB)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO          = 5'd0;
  localparam int         DRAIN_CYCLES_DFLT = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the datapath and the freeze/flush
// controls going back to it.
//   master : datapath side (drives hazard inputs, consumes controls)
//   slave  : hazard controller side
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard inputs
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_halt;
  logic [4:0]       ex_dest;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic             ex_redirect;
  logic             mem_cache_req;
  logic             mem_cache_ready;
  // pipeline controls
  logic             freeze_pc;
  logic             freeze_if_id;
  logic             freeze_id_exe;
  logic             freeze_exe_mem;
  logic             flush_if_id;
  logic             bubble_id_exe;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
           ex_dest, ex_reg_write, ex_mem_to_reg, ex_redirect,
           mem_cache_req, mem_cache_ready,
    input  freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
           flush_if_id, bubble_id_exe, halted, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_halt,
           ex_dest, ex_reg_write, ex_mem_to_reg, ex_redirect,
           mem_cache_req, mem_cache_ready,
    output freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
           flush_if_id, bubble_id_exe, halted, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// load_use_detect: flags an ID instruction that reads the register a load in
// EXE is about to write. Purely combinational.
//   rs, rt, uses_rs, uses_rt        ID source operands and whether they are read
//   ex_dest, ex_reg_write, ex_mem_to_reg   EXE destination and load indication
//   load_use                        one-cycle interlock required
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rs,
  input  logic       uses_rt,
  input  logic [4:0] ex_dest,
  input  logic       ex_reg_write,
  input  logic       ex_mem_to_reg,
  output logic       load_use
);

  logic is_load;
  logic hit_rs;
  logic hit_rt;

  // r0 writes are discarded, so a load to r0 never creates a dependency
  assign is_load  = ex_mem_to_reg & ex_reg_write & (ex_dest != REG_ZERO);
  assign hit_rs   = uses_rs & (rs == ex_dest);
  assign hit_rt   = uses_rt & (rt == ex_dest);
  assign load_use = is_load & (hit_rs | hit_rt);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Handles load-use interlock, cache-miss wait, EXE-resolved redirect and halt
// drain. Controls are combinational from state + inputs so they act in the
// same cycle the hazard is seen.
//   clk, rst_b   clock (rising), async active-low reset
//   hz (slave)   hazard inputs in; freeze/flush/bubble/halted/stall_cycles out
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DFLT,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_b,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e           state;
  logic [DW-1:0]    drain_cnt;
  logic [CNT_W-1:0] stall_q;

  logic mem_miss;
  logic load_use;

  // next-state intent, decoded alongside the outputs
  state_e nxt;
  logic   ld_drain;
  logic   dec_drain;

  logic f_pc, f_if_id, f_id_exe, f_exe_mem, fl_if_id, bub_id_exe, hlt;

  assign mem_miss = hz.mem_cache_req & ~hz.mem_cache_ready;

  load_use_detect u_lud (
    .rs            (hz.id_rs),
    .rt            (hz.id_rt),
    .uses_rs       (hz.id_uses_rs),
    .uses_rt       (hz.id_uses_rt),
    .ex_dest       (hz.ex_dest),
    .ex_reg_write  (hz.ex_reg_write),
    .ex_mem_to_reg (hz.ex_mem_to_reg),
    .load_use      (load_use)
  );

  always_comb begin
    nxt        = state;
    ld_drain   = 1'b0;
    dec_drain  = 1'b0;
    f_pc       = 1'b0;
    f_if_id    = 1'b0;
    f_id_exe   = 1'b0;
    f_exe_mem  = 1'b0;
    fl_if_id   = 1'b0;
    bub_id_exe = 1'b0;
    hlt        = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mem_miss) begin
          {f_pc, f_if_id, f_id_exe, f_exe_mem} = 4'b1111;
          nxt = ST_MEM_WAIT;
        end else if (hz.ex_redirect) begin
          fl_if_id   = 1'b1;
          bub_id_exe = 1'b1;
        end else if (load_use) begin
          f_pc       = 1'b1;
          f_if_id    = 1'b1;
          bub_id_exe = 1'b1;
        end else if (hz.id_halt) begin
          // halt is held in IF/ID and never forwarded; bubbles drain the rest
          f_pc       = 1'b1;
          f_if_id    = 1'b1;
          bub_id_exe = 1'b1;
          ld_drain   = 1'b1;
          nxt        = ST_DRAIN;
        end
      end
      ST_MEM_WAIT: begin
        // pending redirect/load-use sit in frozen regs and resolve in RUN
        if (hz.mem_cache_ready) nxt = ST_RUN;
        else {f_pc, f_if_id, f_id_exe, f_exe_mem} = 4'b1111;
      end
      ST_DRAIN: begin
        if (mem_miss) begin
          // stretch the drain in place; count holds until MEM moves again
          {f_pc, f_if_id, f_id_exe, f_exe_mem} = 4'b1111;
        end else if (hz.ex_redirect) begin
          // halt was on the wrong path
          fl_if_id   = 1'b1;
          bub_id_exe = 1'b1;
          nxt        = ST_RUN;
        end else begin
          f_pc       = 1'b1;
          f_if_id    = 1'b1;
          bub_id_exe = 1'b1;
          if (drain_cnt == '0) nxt = ST_HALTED;
          else                 dec_drain = 1'b1;
        end
      end
      ST_HALTED: begin
        {f_pc, f_if_id, f_id_exe, f_exe_mem} = 4'b1111;
        hlt = 1'b1;
      end
      default: nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_q   <= '0;
    end else begin
      state <= nxt;
      if (ld_drain)       drain_cnt <= DW'(DRAIN_CYCLES - 1);
      else if (dec_drain) drain_cnt <= drain_cnt - 1'b1;
      if ((state == ST_RUN || state == ST_MEM_WAIT) && f_pc && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  // controls forced low while reset is held, whatever the inputs are doing
  assign hz.freeze_pc      = rst_b & f_pc;
  assign hz.freeze_if_id   = rst_b & f_if_id;
  assign hz.freeze_id_exe  = rst_b & f_id_exe;
  assign hz.freeze_exe_mem = rst_b & f_exe_mem;
  assign hz.flush_if_id    = rst_b & fl_if_id;
  assign hz.bubble_id_exe  = rst_b & bub_id_exe;
  assign hz.halted         = rst_b & hlt;
  assign hz.stall_cycles   = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Counter width reduced to 4 so
// saturation is reachable in a short run.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  // output vector bits: fpc fifid fidexe fexemem flush bubble halted
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100010;
  localparam logic [6:0] O_ALLF  = 7'b1111000;
  localparam logic [6:0] O_RED   = 7'b0000110;
  localparam logic [6:0] O_HALTB = 7'b1100010;
  localparam logic [6:0] O_HALT  = 7'b1111001;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {hz.freeze_pc, hz.freeze_if_id, hz.freeze_id_exe, hz.freeze_exe_mem,
                 hz.flush_if_id, hz.bubble_id_exe, hz.halted};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.id_rs           = 5'd0;
    hz.id_rt           = 5'd0;
    hz.id_uses_rs      = 1'b0;
    hz.id_uses_rt      = 1'b0;
    hz.id_halt         = 1'b0;
    hz.ex_dest         = 5'd0;
    hz.ex_reg_write    = 1'b0;
    hz.ex_mem_to_reg   = 1'b0;
    hz.ex_redirect     = 1'b0;
    hz.mem_cache_req   = 1'b0;
    hz.mem_cache_ready = 1'b0;
  endtask

  task automatic load_r5_rs5();
    hz.ex_dest       = 5'd5;
    hz.ex_reg_write  = 1'b1;
    hz.ex_mem_to_reg = 1'b1;
    hz.id_rs         = 5'd5;
    hz.id_uses_rs    = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_b = 1'b0;
    #12;
    chk("rst_outs", 32'(outs), 32'(O_NONE));
    chk("rst_stall", 32'(hz.stall_cycles), 0);
    @(negedge clk); rst_b = 1'b1;

    // load-use via rs, then clears once the load moves on
    @(negedge clk); load_r5_rs5(); #1 chk("lu_rs", 32'(outs), 32'(O_LU));
    @(negedge clk); hz.ex_mem_to_reg = 1'b0; #1 chk("lu_clear", 32'(outs), 32'(O_NONE));
    chk("lu_stall", 32'(hz.stall_cycles), 1);
    @(negedge clk); idle(); load_r5_rs5(); hz.ex_dest = 5'd0; hz.id_rs = 5'd0;
    #1 chk("lu_r0", 32'(outs), 32'(O_NONE));
    @(negedge clk); idle(); load_r5_rs5(); hz.id_uses_rs = 1'b0;
    #1 chk("lu_unused_rs", 32'(outs), 32'(O_NONE));
    @(negedge clk); hz.id_uses_rt = 1'b1; hz.id_rt = 5'd5;
    #1 chk("lu_rt", 32'(outs), 32'(O_LU));
    @(negedge clk); hz.ex_reg_write = 1'b0; #1 chk("lu_noregwr", 32'(outs), 32'(O_NONE));
    chk("lu_stall2", 32'(hz.stall_cycles), 2);

    // cache miss, ready after 4 frozen cycles
    @(negedge clk); idle(); hz.mem_cache_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("miss_%0d", i), 32'(outs), 32'(O_ALLF));
      @(negedge clk);
    end
    hz.mem_cache_ready = 1'b1; #1 chk("miss_ready", 32'(outs), 32'(O_NONE));
    @(negedge clk); idle(); #1 chk("miss_after", 32'(outs), 32'(O_NONE));
    chk("miss_stall", 32'(hz.stall_cycles), 6);

    // redirect overrides load-use
    @(negedge clk); load_r5_rs5(); hz.ex_redirect = 1'b1;
    #1 chk("red_lu", 32'(outs), 32'(O_RED));

    // halt drain: 3 drain cycles then sticky halted
    @(negedge clk); idle(); hz.id_halt = 1'b1; #1 chk("halt_run", 32'(outs), 32'(O_HALTB));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); #1 chk($sformatf("drain_%0d", i), 32'(outs), 32'(O_HALTB));
    end
    @(negedge clk); #1 chk("halted", 32'(outs), 32'(O_HALT));
    @(negedge clk); hz.ex_redirect = 1'b1; hz.mem_cache_req = 1'b1;
    #1 chk("halted_sticky", 32'(outs), 32'(O_HALT));
    chk("halt_stall", 32'(hz.stall_cycles), 7);

    // async reset while halted and a miss is presented
    @(negedge clk); rst_b = 1'b0; #1 chk("rst_async", 32'(outs), 32'(O_NONE));
    chk("rst_async_stall", 32'(hz.stall_cycles), 0);
    @(negedge clk); idle(); rst_b = 1'b1; #1 chk("rst_release", 32'(outs), 32'(O_NONE));

    // halt on wrong path: redirect in 2nd drain cycle
    @(negedge clk); hz.id_halt = 1'b1; #1 chk("wp_halt", 32'(outs), 32'(O_HALTB));
    @(negedge clk); idle(); #1 chk("wp_drain1", 32'(outs), 32'(O_HALTB));
    @(negedge clk); hz.ex_redirect = 1'b1; #1 chk("wp_redirect", 32'(outs), 32'(O_RED));
    @(negedge clk); idle(); #1 chk("wp_run", 32'(outs), 32'(O_NONE));

    // miss during drain stretches it by one cycle
    @(negedge clk); hz.id_halt = 1'b1; #1 chk("dm_halt", 32'(outs), 32'(O_HALTB));
    @(negedge clk); idle(); hz.mem_cache_req = 1'b1; #1 chk("dm_miss", 32'(outs), 32'(O_ALLF));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); #1 chk($sformatf("dm_drain_%0d", i), 32'(outs), 32'(O_HALTB));
    end
    @(negedge clk); #1 chk("dm_halted", 32'(outs), 32'(O_HALT));
    chk("dm_stall", 32'(hz.stall_cycles), 2);

    // reset mid-drain
    @(negedge clk); rst_b = 1'b0;
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); hz.id_halt = 1'b1;
    @(negedge clk); idle(); #1 chk("rd_drain", 32'(outs), 32'(O_HALTB));
    #2 rst_b = 1'b0; hz.mem_cache_req = 1'b1; #1 chk("rd_reset", 32'(outs), 32'(O_NONE));
    @(negedge clk); idle(); rst_b = 1'b1; #1 chk("rd_run", 32'(outs), 32'(O_NONE));
    @(negedge clk); #1 chk("rd_run2", 32'(outs), 32'(O_NONE));

    // saturation of 4-bit stall counter
    @(negedge clk); hz.mem_cache_req = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #1 chk("sat_frozen", 32'(outs), 32'(O_ALLF));
    chk("sat_stall", 32'(hz.stall_cycles), 15);
    @(negedge clk); hz.mem_cache_ready = 1'b1; #1 chk("sat_ready", 32'(outs), 32'(O_NONE));
    @(negedge clk); idle(); #1 chk("sat_hold", 32'(hz.stall_cycles), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
